pi_com_spi: RTL and testbench
=============================

// Module: pi_com_spi
// PURPOSE
// - SPI (mode 0) slave that turns 4-byte Raspberry Pi commands into a bus request {addr, data, rw_b}
//   for the PET memory arbiter; sits between the Pi's SPI pins and the bus-side arbiter.
// - Completes each request with a pending/done four-phase handshake against the arbiter.
// PARAMETERS
// - ADDR_W       17  bus address width (A16..A0)
// - SYNC_STAGES  2   flops used to synchronise pi_done_in into the spi_sclk domain
// PORTS
// - spi_sclk        in   1   sole clock: SPI clock; rx sampled on rising edge
// - reset           in   1   synchronous, active-high reset
// - spi_cs_n        in   1   chip select, active low; high = idle, aborts and restarts framing
// - spi_rx          in   1   MOSI
// - spi_tx          out  1   MISO
// - pi_addr         out  17  latched request address
// - pi_data_out     out  8   latched write data
// - pi_data_in      in   8   read data from the bus, captured on done
// - pi_rw_b         out  1   1 = read, 0 = write
// - pi_pending_in   in   1   arbiter enable: requests are offered only while high
// - pi_pending_out  out  1   request valid towards arbiter
// - pi_done_in      in   1   arbiter completion (level, four-phase)
// - pi_done_out     out  1   synchronised completion towards Pi
// BEHAVIOUR
// - Reset: pi_addr=0, pi_data_out=0, pi_rw_b=1, pi_pending_out=0, pi_done_out=0, spi_tx=0, counters=0.
// - Framing: MSB first. spi_cs_n high clears bit and byte counters synchronously. The first posedge with
//   cs_n low samples bit 7 of byte 0.
// - Byte 0 = command: bit7 = rw_b, bit6 = A16, bits5..0 reserved (ignored).
// - Byte 1 = A15..A8; byte 2 = A7..A0.
// - Byte 3 = write data; it is present only when rw_b=0.
// - Each field register updates on the posedge that completes its byte. Write: pi_addr/pi_rw_b/pi_data_out
//   final after byte 3. Read: final after byte 2.
// - On command completion (byte 3 for writes, byte 2 for reads), set cmd_valid.
//   pi_pending_out = cmd_valid & pi_pending_in.
// - Bytes beyond the command are ignored until cs_n rises.
// - If cs_n rises before the command completes, partial fields are discarded and cmd_valid is not set.
// - pi_done_in passes through a SYNC_STAGES flop chain; the final stage drives pi_done_out.
// - On the synchronised rising edge of done: clear cmd_valid. If pi_rw_b=1, capture pi_data_in into rd_data.
// - pi_addr, pi_data_out and pi_rw_b stay stable from completion until the next command completes. They
//   must still be valid when pi_done_out rises.
// - A new command that completes while cmd_valid=1 overwrites the fields and keeps cmd_valid=1
//   (last command wins).
// - spi_tx shifts out rd_data MSB first in every byte slot. It is updated on the falling edge of spi_sclk
//   so the data is stable before the master's rising edge. It is 0 while cs_n is high.
// - A synchronous reset mid-transfer behaves like a cs_n abort and also clears cmd_valid and the sync chain.
// STRUCTURE
// - Shared package: CMD_RW_BIT=7, CMD_A16_BIT=6, CMD_BYTES_WR=4, CMD_BYTES_RD=3.
// - One sub-module, spi_byte_shift. Ports: spi_sclk, reset, spi_cs_n, spi_rx, spi_tx, rx[7:0], tx[7:0],
//   done (one-cycle pulse on the 8th bit).
// - pi_com_spi contains the byte counter, field registers, cmd_valid, done sync and rd_data.
// TESTING
// - Write: pending_in=1; bytes 40,55,81,7E, cs_n high; done_in=1
//   -> pending_out=1 after byte 3; at done_out rise addr=15581, data_out=7E, rw_b=0.
// - Handshake release: then done_in=0 -> pending_out stays 0 and done_out falls after 2 sclk;
//   pending_in=0 -> no new request.
// - Read: bytes 80,12,34; pi_data_in=A5, done_in=1 -> addr=01234, rw_b=1.
//   The next transfer's first byte on spi_tx = A5.
// - Abort: cs_n high after bytes 40,55 -> pending_out stays 0 and the fields keep their previous values.
// - Gating: pending_in=0 during a complete write -> pending_out=0. Raising pending_in later -> pending_out=1.
// - Reset mid-byte: reset=1 for 1 sclk during byte 1 -> all outputs at reset values.
//   The next full command 00,00,10,FF -> addr=00010, data_out=FF.

Source files
------------

// File: rtl/pi_com_spi_pkg.sv
// Shared constants for the Pi SPI command slave.
// Command layout: byte 0 = {rw_b, A16, reserved[5:0]}, byte 1 = A15..A8, byte 2 = A7..A0,
// byte 3 = write data (writes only).
package pi_com_spi_pkg;

    localparam int unsigned CMD_RW_BIT   = 7;
    localparam int unsigned CMD_A16_BIT  = 6;
    localparam int unsigned CMD_BYTES_WR = 4;
    localparam int unsigned CMD_BYTES_RD = 3;

    // Index of the byte that completes a command of the given direction.
    function automatic logic [2:0] cmd_last_byte(input logic rw_b);
        return rw_b ? 3'(CMD_BYTES_RD - 1) : 3'(CMD_BYTES_WR - 1);
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// SPI mode 0 byte shifter (slave side), MSB first.
// Ports:
//   spi_sclk  in   SPI clock; spi_rx sampled on the rising edge
//   reset     in   synchronous active-high reset
//   spi_cs_n  in   chip select, active low; high clears the bit counter
//   spi_rx    in   MOSI
//   spi_tx    out  MISO, updated on the falling edge, 0 while spi_cs_n is high
//   rx        out  received byte, valid together with done
//   tx        in   byte to shift out in every byte slot
//   done      out  high during the bit time whose rising edge completes a byte
module spi_byte_shift (
    input  logic       spi_sclk,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_rx,
    output logic       spi_tx,
    output logic [7:0] rx,
    input  logic [7:0] tx,
    output logic       done
);

    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sh_q, sh_d;
    logic       tx_q;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (spi_cs_n) begin
            cnt_d = 3'd0;
        end else begin
            cnt_d = cnt_q + 3'd1;
            sh_d  = {sh_q[5:0], spi_rx};
        end
    end

    always_ff @(posedge spi_sclk) begin
        if (reset) begin
            cnt_q <= 3'd0;
            sh_q  <= 7'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

    // The byte is presented combinationally so the parent can register it on the
    // same rising edge that samples bit 0.
    assign rx   = {sh_q, spi_rx};
    assign done = ~reset & ~spi_cs_n & (cnt_q == 3'd7);

    // With cs_n high the counter sits at 0, so bit 7 is already on tx_q when cs_n
    // falls and the master's first rising edge sees it.
    always_ff @(negedge spi_sclk) begin
        if (reset) begin
            tx_q <= 1'b0;
        end else begin
            tx_q <= tx[3'd7 - cnt_q];
        end
    end

    assign spi_tx = tx_q & ~spi_cs_n;

endmodule

// File: rtl/pi_com_spi.sv
// Raspberry Pi SPI command slave: turns 3/4-byte SPI commands into a bus request
// {addr, data, rw_b} and completes it with a pending/done four-phase handshake.
// Ports:
//   spi_sclk, reset, spi_cs_n, spi_rx, spi_tx  SPI pins (spi_sclk is the only clock)
//   pi_addr, pi_data_out, pi_rw_b              latched request fields
//   pi_data_in                                 read data, captured on done
//   pi_pending_in / pi_pending_out             arbiter enable / request valid
//   pi_done_in / pi_done_out                   arbiter completion / synchronised completion
module pi_com_spi
    import pi_com_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              spi_sclk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_rx,
    output logic              spi_tx,
    output logic [ADDR_W-1:0] pi_addr,
    output logic [7:0]        pi_data_out,
    input  logic [7:0]        pi_data_in,
    output logic              pi_rw_b,
    input  logic              pi_pending_in,
    output logic              pi_pending_out,
    input  logic              pi_done_in,
    output logic              pi_done_out
);

    // Byte counter value meaning "command finished, ignore further bytes".
    localparam logic [2:0] BytesEnd = 3'(CMD_BYTES_WR);

    logic [7:0]             rx_byte;
    logic                   byte_done;
    logic                   cmd_done;
    logic [16:0]            addr_full;

    logic [2:0]             byte_q, byte_d;
    logic                   cmd_rw_q, cmd_rw_d;
    logic                   cmd_a16_q, cmd_a16_d;
    logic [7:0]             addr_hi_q, addr_hi_d;
    logic [7:0]             addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic                   rw_b_q, rw_b_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   done_prev_q;
    logic                   done_rise;

    spi_byte_shift u_shift (
        .spi_sclk (spi_sclk),
        .reset    (reset),
        .spi_cs_n (spi_cs_n),
        .spi_rx   (spi_rx),
        .spi_tx   (spi_tx),
        .rx       (rx_byte),
        .tx       (rd_data_q),
        .done     (byte_done)
    );

    assign done_rise = sync_q[SYNC_STAGES-1] & ~done_prev_q;

    // Reads take the low address byte straight off the wire; writes staged it earlier.
    assign addr_full = cmd_rw_q ? {cmd_a16_q, addr_hi_q, rx_byte}
                                : {cmd_a16_q, addr_hi_q, addr_lo_q};

    always_comb begin
        byte_d      = byte_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_a16_d   = cmd_a16_q;
        addr_hi_d   = addr_hi_q;
        addr_lo_d   = addr_lo_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_b_d      = rw_b_q;
        rd_data_d   = rd_data_q;
        cmd_done    = 1'b0;
        sync_d      = SYNC_STAGES'({sync_q, pi_done_in});

        // Partial fields live only in the staging registers, so an abort leaves the
        // visible request untouched.
        if (spi_cs_n) begin
            byte_d = 3'd0;
        end else if (byte_done && (byte_q < BytesEnd)) begin
            case (byte_q)
                3'd0: begin
                    cmd_rw_d  = rx_byte[CMD_RW_BIT];
                    cmd_a16_d = rx_byte[CMD_A16_BIT];
                end
                3'd1:    addr_hi_d = rx_byte;
                3'd2:    addr_lo_d = rx_byte;
                default: ;
            endcase

            if (byte_q == cmd_last_byte(cmd_rw_q)) begin
                cmd_done = 1'b1;
                addr_d   = ADDR_W'(addr_full);
                rw_b_d   = cmd_rw_q;
                if (!cmd_rw_q) begin
                    data_d = rx_byte;
                end
                byte_d   = BytesEnd;
            end else begin
                byte_d   = byte_q + 3'd1;
            end
        end

        // rw_b_q still describes the request being acknowledged here.
        if (done_rise && rw_b_q) begin
            rd_data_d = pi_data_in;
        end

        // A command completing on the acknowledge edge wins: last command stays pending.
        cmd_valid_d = cmd_valid_q;
        if (done_rise) begin
            cmd_valid_d = 1'b0;
        end
        if (cmd_done) begin
            cmd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge spi_sclk) begin
        if (reset) begin
            byte_q      <= 3'd0;
            cmd_rw_q    <= 1'b1;
            cmd_a16_q   <= 1'b0;
            addr_hi_q   <= 8'd0;
            addr_lo_q   <= 8'd0;
            addr_q      <= '0;
            data_q      <= 8'd0;
            rw_b_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            rd_data_q   <= 8'd0;
            sync_q      <= '0;
            done_prev_q <= 1'b0;
        end else begin
            byte_q      <= byte_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_a16_q   <= cmd_a16_d;
            addr_hi_q   <= addr_hi_d;
            addr_lo_q   <= addr_lo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_b_q      <= rw_b_d;
            cmd_valid_q <= cmd_valid_d;
            rd_data_q   <= rd_data_d;
            sync_q      <= sync_d;
            done_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pi_addr        = addr_q;
    assign pi_data_out    = data_q;
    assign pi_rw_b        = rw_b_q;
    assign pi_pending_out = cmd_valid_q & pi_pending_in;
    assign pi_done_out    = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pi_com_spi.sv
// Bench for pi_com_spi: SPI master tasks drive commands, expected requests go into a
// queue, and a monitor compares the request fields on every rise of pi_done_out.
module tb_pi_com_spi;

    logic        spi_sclk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_rx = 1'b0;
    logic        spi_tx;
    logic [16:0] pi_addr;
    logic [7:0]  pi_data_out;
    logic [7:0]  pi_data_in = 8'h00;
    logic        pi_rw_b;
    logic        pi_pending_in = 1'b0;
    logic        pi_pending_out;
    logic        pi_done_in = 1'b0;
    logic        pi_done_out;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        rw_b;
    } req_t;

    req_t        exp_q[$];
    req_t        mon_req;
    logic        mon_prev = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  last_miso;

    always #5 spi_sclk = ~spi_sclk;

    pi_com_spi #(
        .ADDR_W      (17),
        .SYNC_STAGES (2)
    ) dut (
        .spi_sclk       (spi_sclk),
        .reset          (reset),
        .spi_cs_n       (spi_cs_n),
        .spi_rx         (spi_rx),
        .spi_tx         (spi_tx),
        .pi_addr        (pi_addr),
        .pi_data_out    (pi_data_out),
        .pi_data_in     (pi_data_in),
        .pi_rw_b        (pi_rw_b),
        .pi_pending_in  (pi_pending_in),
        .pi_pending_out (pi_pending_out),
        .pi_done_in     (pi_done_in),
        .pi_done_out    (pi_done_out)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [16:0] a, input logic [7:0] d, input logic rw);
        req_t r;
        r.addr = a;
        r.data = d;
        r.rw_b = rw;
        exp_q.push_back(r);
    endtask

    // Monitor: every rising pi_done_out must match the oldest expected request.
    always @(negedge spi_sclk) begin
        if (pi_done_out && !mon_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done_out rose with no request expected (t=%0t)",
                         $time);
            end else begin
                mon_req = exp_q.pop_front();
                check("req_addr", 32'(pi_addr), 32'(mon_req.addr));
                check("req_data", 32'(pi_data_out), 32'(mon_req.data));
                check("req_rw_b", 32'(pi_rw_b), 32'(mon_req.rw_b));
            end
        end
        mon_prev <= pi_done_out;
    end

    // Mode 0 master: drive after the falling edge, sample MISO just before the rising edge.
    // rst_bit >= 0 pulses reset for one sclk during that bit.
    task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int nbytes, input int rst_bit);
        logic [7:0] bs[4];
        int         idx;
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        bs[3] = b3;
        @(negedge spi_sclk);
        #1;
        spi_cs_n = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            for (int i = 7; i >= 0; i--) begin
                idx = k * 8 + (7 - i);
                if (idx != 0) begin
                    @(negedge spi_sclk);
                    #1;
                end
                reset  = (idx == rst_bit);
                spi_rx = bs[k][i];
                #3;
                if (k == 0) last_miso[i] = spi_tx;
            end
        end
        @(negedge spi_sclk);
        #1;
        reset    = 1'b0;
        spi_cs_n = 1'b1;
        spi_rx   = 1'b0;
    endtask

    task automatic wait_done_out(input logic lvl);
        int n = 0;
        while (pi_done_out !== lvl && n < 20) begin
            @(negedge spi_sclk);
            n++;
        end
        check("done_out_reached", 32'(pi_done_out), 32'(lvl));
    endtask

    task automatic wait_pending(input logic lvl);
        int n = 0;
        while (pi_pending_out !== lvl && n < 20) begin
            @(negedge spi_sclk);
            n++;
        end
        check("pending_reached", 32'(pi_pending_out), 32'(lvl));
    endtask

    // Full four-phase completion; done_out must fall exactly two sclk after done_in.
    task automatic handshake(input logic [7:0] rd);
        pi_data_in = rd;
        pi_done_in = 1'b1;
        wait_done_out(1'b1);
        wait_pending(1'b0);
        pi_done_in = 1'b0;
        @(negedge spi_sclk);
        check("done_hold_1clk", 32'(pi_done_out), 32'd1);
        @(negedge spi_sclk);
        check("done_fall_2clk", 32'(pi_done_out), 32'd0);
        check("pending_after_done", 32'(pi_pending_out), 32'd0);
    endtask

    initial begin
        // Reset with pending_in high so a stray cmd_valid would show.
        pi_pending_in = 1'b1;
        repeat (3) @(negedge spi_sclk);
        #1;
        reset = 1'b0;
        check("rst_addr", 32'(pi_addr), 32'h0);
        check("rst_data", 32'(pi_data_out), 32'h0);
        check("rst_rw_b", 32'(pi_rw_b), 32'h1);
        check("rst_pending", 32'(pi_pending_out), 32'h0);
        check("rst_done_out", 32'(pi_done_out), 32'h0);
        check("rst_spi_tx", 32'(spi_tx), 32'h0);

        // Write 40 55 81 7E -> addr 15581, data 7E.
        xfer(8'h40, 8'h55, 8'h81, 8'h7E, 4, -1);
        check("tx_after_reset", 32'(last_miso), 32'h00);
        check("wr_pending", 32'(pi_pending_out), 32'h1);
        push_exp(17'h15581, 8'h7E, 1'b0);
        handshake(8'h99);

        // Released with pending_in low: nothing new may be offered.
        pi_pending_in = 1'b0;
        repeat (4) @(negedge spi_sclk);
        check("no_new_req", 32'(pi_pending_out), 32'h0);

        // Read 80 12 34 -> addr 01234; write ack must not have loaded rd_data.
        pi_pending_in = 1'b1;
        xfer(8'h80, 8'h12, 8'h34, 8'h00, 3, -1);
        check("tx_no_wr_capture", 32'(last_miso), 32'h00);
        check("rd_pending", 32'(pi_pending_out), 32'h1);
        push_exp(17'h01234, 8'h7E, 1'b1);
        handshake(8'hA5);

        // Next transfer's first byte carries the captured read data.
        xfer(8'h00, 8'h00, 8'h00, 8'h00, 1, -1);
        check("tx_rd_data", 32'(last_miso), 32'hA5);

        // Abort after two bytes: no request, fields unchanged.
        xfer(8'h40, 8'h55, 8'h00, 8'h00, 2, -1);
        check("abort_pending", 32'(pi_pending_out), 32'h0);
        check("abort_addr", 32'(pi_addr), 32'h01234);
        check("abort_rw_b", 32'(pi_rw_b), 32'h1);
        check("abort_data", 32'(pi_data_out), 32'h7E);

        // Gating, reserved bits ignored, last command wins.
        pi_pending_in = 1'b0;
        xfer(8'h3F, 8'hAB, 8'hCD, 8'h3C, 4, -1);
        check("gate_pending_0", 32'(pi_pending_out), 32'h0);
        check("gate_addr", 32'(pi_addr), 32'h0ABCD);
        xfer(8'h7F, 8'h00, 8'h01, 8'h11, 4, -1);
        check("gate_pending_1", 32'(pi_pending_out), 32'h0);
        pi_pending_in = 1'b1;
        @(negedge spi_sclk);
        check("gate_release", 32'(pi_pending_out), 32'h1);
        push_exp(17'h10001, 8'h11, 1'b0);
        handshake(8'h00);

        // Leave a request pending, then reset mid byte 1.
        xfer(8'h00, 8'h00, 8'h22, 8'h33, 4, -1);
        check("pre_rst_pending", 32'(pi_pending_out), 32'h1);
        xfer(8'h40, 8'h55, 8'h00, 8'h00, 2, 11);
        check("mid_rst_addr", 32'(pi_addr), 32'h0);
        check("mid_rst_data", 32'(pi_data_out), 32'h0);
        check("mid_rst_rw_b", 32'(pi_rw_b), 32'h1);
        check("mid_rst_pending", 32'(pi_pending_out), 32'h0);
        check("mid_rst_done_out", 32'(pi_done_out), 32'h0);
        check("mid_rst_spi_tx", 32'(spi_tx), 32'h0);

        xfer(8'h00, 8'h00, 8'h10, 8'hFF, 4, -1);
        check("post_rst_pending", 32'(pi_pending_out), 32'h1);
        push_exp(17'h00010, 8'hFF, 1'b0);
        handshake(8'h00);

        repeat (3) @(negedge spi_sclk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
